mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer for the 2:1 4-bit data mux path.
- Two producer lanes present 4-bit words with valid/ready handshakes. The block decides which lane owns the shared output each cycle and enforces a burst limit so neither lane starves.
- The winning word goes into a single-entry output register with valid/ready backpressure from the downstream consumer.
- Sits between the lane producers and the downstream consumer; it replaces the free-running toggle selector with demand-driven selection.

---
 rtl/mux_rr_arbiter.sv | 112 +++++++++++
 tb/tb_mux_rr_arbiter.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter for two 4-bit producer lanes feeding one registered output slot.
// A lane keeps ownership for up to BURST_MAX consecutive wins while the other lane waits.
module mux_rr_arbiter #(
  parameter int BURST_MAX = 4,
  parameter int CNT_W     = 4
) (
  input  logic       clk,
  input  logic       reset_L,
  input  logic       valid_0,
  input  logic [3:0] data_0,
  output logic       ready_0,
  input  logic       valid_1,
  input  logic [3:0] data_1,
  output logic       ready_1,
  output logic [3:0] data_out,
  output logic       valid_out,
  output logic       src_out,
  input  logic       out_ready,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  localparam logic [CNT_W-1:0] LP_MAX = CNT_W'(BURST_MAX);

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_last, w_last_nxt;
  logic [3:0]       r_data;
  logic             r_valid;
  logic             r_src;

  logic             w_can_load;
  logic             w_win;
  logic             w_xfer;
  logic             w_owned;
  logic [3:0]       w_data_sel;

  // Winner is only meaningful when at least one lane is valid.
  always_comb begin
    w_win = 1'b0;
    if (valid_0 && !valid_1) begin
      w_win = 1'b0;
    end else if (valid_1 && !valid_0) begin
      w_win = 1'b1;
    end else if (valid_0 && valid_1) begin
      case (r_state)
        OWN0:    w_win = (r_cnt >= LP_MAX);
        OWN1:    w_win = (r_cnt <  LP_MAX);
        default: w_win = ~r_last;
      endcase
    end
  end

  assign w_can_load = !r_valid || out_ready;
  assign ready_0    = w_can_load && valid_0 && !w_win;
  assign ready_1    = w_can_load && valid_1 &&  w_win;
  assign w_xfer     = ready_0 || ready_1;
  assign w_owned    = w_win ? (r_state == OWN1) : (r_state == OWN0);
  assign w_data_sel = w_win ? data_1 : data_0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_last_nxt  = r_last;
    if (w_xfer) begin
      w_state_nxt = w_win ? OWN1 : OWN0;
      w_last_nxt  = w_win;
      if (!w_owned) begin
        w_cnt_nxt = CNT_W'(1);
      end else if (r_cnt < LP_MAX) begin
        w_cnt_nxt = r_cnt + CNT_W'(1);
      end
    end else if (w_can_load) begin
      // Output slot free and nobody asking: give up ownership entirely.
      w_state_nxt = IDLE;
      w_cnt_nxt   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_last  <= 1'b1;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_last  <= w_last_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      r_data  <= '0;
      r_valid <= 1'b0;
      r_src   <= 1'b0;
    end else if (w_xfer) begin
      r_data  <= w_data_sel;
      r_valid <= 1'b1;
      r_src   <= w_win;
    end else if (w_can_load) begin
      r_valid <= 1'b0;
    end
  end

  assign data_out  = r_data;
  assign valid_out = r_valid;
  assign src_out   = r_src;
  assign busy      = (r_state != IDLE);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter: directed scenarios plus random traffic
// compared against a behavioural model of the arbitration rules.
module tb_mux_rr_arbiter;
  localparam int BURST_MAX = 4;

  logic       clk = 1'b0;
  logic       reset_L;
  logic       valid_0, valid_1, out_ready;
  logic [3:0] data_0, data_1;
  logic       ready_0, ready_1, valid_out, src_out, busy;
  logic [3:0] data_out;

  int n_chk  = 0;
  int n_pass = 0;

  // Behavioural model: owner -1 means nobody owns the output.
  int         m_owner, m_cnt, m_last;
  logic [3:0] m_dout;
  logic       m_vout, m_src;
  logic       e_r0, e_r1, a_r0, a_r1;

  mux_rr_arbiter #(.BURST_MAX(BURST_MAX), .CNT_W(4)) dut (
    .clk(clk), .reset_L(reset_L),
    .valid_0(valid_0), .data_0(data_0), .ready_0(ready_0),
    .valid_1(valid_1), .data_1(data_1), .ready_1(ready_1),
    .data_out(data_out), .valid_out(valid_out), .src_out(src_out),
    .out_ready(out_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic int m_winner(input logic v0, input logic v1);
    if (!v0 && !v1) return -1;
    if (v0 && !v1) return 0;
    if (v1 && !v0) return 1;
    if (m_owner < 0) return 1 - m_last;
    if (m_cnt >= BURST_MAX) return 1 - m_owner;
    return m_owner;
  endfunction

  task automatic m_reset();
    m_owner = -1; m_cnt = 0; m_last = 1;
    m_dout = 4'h0; m_vout = 1'b0; m_src = 1'b0;
  endtask

  // Drives one cycle starting at posedge+1, records readies, advances the model.
  task automatic cycle(input logic v0, input logic [3:0] d0,
                       input logic v1, input logic [3:0] d1, input logic ordy);
    int   w;
    logic cl;
    valid_0 = v0; data_0 = d0; valid_1 = v1; data_1 = d1; out_ready = ordy;
    #2;
    cl = !m_vout || ordy;
    w  = m_winner(v0, v1);
    e_r0 = cl && (w == 0);
    e_r1 = cl && (w == 1);
    a_r0 = ready_0;
    a_r1 = ready_1;
    @(posedge clk);
    if (cl) begin
      if (w >= 0) begin
        m_cnt   = (m_owner == w) ? ((m_cnt < BURST_MAX) ? m_cnt + 1 : BURST_MAX) : 1;
        m_owner = w;
        m_last  = w;
        m_dout  = (w == 1) ? d1 : d0;
        m_vout  = 1'b1;
        m_src   = (w == 1);
      end else begin
        m_owner = -1;
        m_cnt   = 0;
        m_vout  = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset();
    valid_0 = 0; valid_1 = 0; data_0 = 0; data_1 = 0; out_ready = 0;
    reset_L = 1'b0;
    #2;
    reset_L = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    do_reset();
    n_chk++; if (valid_out !== 1'b0) $display("FAIL rst_valid: got %b want 0", valid_out); else n_pass++;
    n_chk++; if (data_out !== 4'h0) $display("FAIL rst_data: got %h want 0", data_out); else n_pass++;
    n_chk++; if (busy !== 1'b0 || src_out !== 1'b0) $display("FAIL rst_busy_src: got %b%b want 00", busy, src_out); else n_pass++;
    cycle(1'b0, 4'h0, 1'b1, 4'h9, 1'b0);
    n_chk++; if (valid_out !== 1'b1 || data_out !== 4'h9) $display("FAIL rst_preload: got %b/%h want 1/9", valid_out, data_out); else n_pass++;
    reset_L = 1'b0;
    #2;
    n_chk++; if (valid_out !== 1'b0 || data_out !== 4'h0 || busy !== 1'b0)
      $display("FAIL rst_async: got v%b d%h b%b want v0 d0 b0", valid_out, data_out, busy); else n_pass++;
    reset_L = 1'b1;
    m_reset();
    cycle(1'b1, 4'h1, 1'b1, 4'h2, 1'b1);
    n_chk++; if (a_r0 !== 1'b1 || a_r1 !== 1'b0) $display("FAIL rst_first_win: got r0=%b r1=%b want 1 0", a_r0, a_r1); else n_pass++;
    n_chk++; if (src_out !== 1'b0 || data_out !== 4'h1) $display("FAIL rst_first_src: got %b/%h want 0/1", src_out, data_out); else n_pass++;
  endtask

  task automatic test_single_lane();
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      cycle(1'b1, 4'(k), 1'b0, 4'hF, 1'b1);
      n_chk++; if (a_r0 !== 1'b1 || a_r1 !== 1'b0) $display("FAIL single_ready[%0d]: got %b%b want 10", k, a_r0, a_r1); else n_pass++;
      n_chk++; if (data_out !== 4'(k) || src_out !== 1'b0 || valid_out !== 1'b1)
        $display("FAIL single_out[%0d]: got %h/%b/%b want %h/0/1", k, data_out, src_out, valid_out, 4'(k)); else n_pass++;
    end
  endtask

  task automatic test_contention();
    do_reset();
    for (int i = 0; i < 12; i++) begin
      cycle(1'b1, 4'(i), 1'b1, 4'(i + 8), 1'b1);
      n_chk++; if (src_out !== 1'((i / 4) % 2) || valid_out !== 1'b1)
        $display("FAIL contend_src[%0d]: got %b/%b want %0d/1", i, src_out, valid_out, (i / 4) % 2); else n_pass++;
      n_chk++; if (data_out !== m_dout) $display("FAIL contend_data[%0d]: got %h want %h", i, data_out, m_dout); else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    cycle(1'b1, 4'hA, 1'b0, 4'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 4'h5, 1'b1, 4'h6, 1'b0);
      n_chk++; if (a_r0 !== 1'b0 || a_r1 !== 1'b0) $display("FAIL bp_ready[%0d]: got %b%b want 00", i, a_r0, a_r1); else n_pass++;
      n_chk++; if (data_out !== 4'hA || valid_out !== 1'b1) $display("FAIL bp_hold[%0d]: got %h/%b want a/1", i, data_out, valid_out); else n_pass++;
    end
    cycle(1'b1, 4'h5, 1'b1, 4'h6, 1'b1);
    n_chk++; if (a_r0 !== 1'b1 || a_r1 !== 1'b0) $display("FAIL bp_release_ready: got %b%b want 10", a_r0, a_r1); else n_pass++;
    n_chk++; if (data_out !== 4'h5 || src_out !== 1'b0) $display("FAIL bp_release_data: got %h/%b want 5/0", data_out, src_out); else n_pass++;
  endtask

  task automatic test_late_requester();
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1'b1, 4'(i), 1'b0, 4'h0, 1'b1);
    n_chk++; if (busy !== 1'b1 || src_out !== 1'b0) $display("FAIL late_stream: got b%b s%b want b1 s0", busy, src_out); else n_pass++;
    cycle(1'b1, 4'h7, 1'b1, 4'h8, 1'b1);
    n_chk++; if (a_r1 !== 1'b1 || a_r0 !== 1'b0) $display("FAIL late_ready: got r0=%b r1=%b want 0 1", a_r0, a_r1); else n_pass++;
    n_chk++; if (src_out !== 1'b1 || data_out !== 4'h8) $display("FAIL late_out: got %b/%h want 1/8", src_out, data_out); else n_pass++;
  endtask

  task automatic test_drain();
    cycle(1'b0, 4'h0, 1'b0, 4'h0, 1'b1);
    n_chk++; if (valid_out !== 1'b0 || busy !== 1'b0) $display("FAIL drain_idle: got v%b b%b want v0 b0", valid_out, busy); else n_pass++;
    n_chk++; if (data_out !== 4'h8 || src_out !== 1'b1) $display("FAIL drain_hold: got %h/%b want 8/1", data_out, src_out); else n_pass++;
    cycle(1'b1, 4'h3, 1'b1, 4'h4, 1'b1);
    n_chk++; if (src_out !== 1'b0 || data_out !== 4'h3) $display("FAIL drain_next_win: got %b/%h want 0/3", src_out, data_out); else n_pass++;
  endtask

  task automatic test_random();
    int errs;
    errs = 0;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle(1'($urandom_range(0, 1)), 4'($urandom), 1'($urandom_range(0, 1)), 4'($urandom),
            1'($urandom_range(0, 3) != 0));
      n_chk++;
      if (a_r0 !== e_r0 || a_r1 !== e_r1) begin
        if (errs < 10) $display("FAIL rand_ready[%0d]: got %b%b want %b%b", i, a_r0, a_r1, e_r0, e_r1);
        errs++;
      end else n_pass++;
      n_chk++;
      if (valid_out !== m_vout || data_out !== m_dout || src_out !== m_src || busy !== (m_owner >= 0)) begin
        if (errs < 10) $display("FAIL rand_out[%0d]: got v%b d%h s%b b%b want v%b d%h s%b b%b", i,
          valid_out, data_out, src_out, busy, m_vout, m_dout, m_src, (m_owner >= 0));
        errs++;
      end else n_pass++;
    end
  endtask

  initial begin
    reset_L = 1'b1;
    valid_0 = 0; valid_1 = 0; data_0 = 0; data_1 = 0; out_ready = 0;
    m_reset();
    @(posedge clk);
    #1;
    test_reset();
    test_single_lane();
    test_contention();
    test_backpressure();
    test_late_requester();
    test_drain();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
